// File: rtl/transram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : transram_ctrl
// Purpose  : Sequencer and output stage for the 8x8 transpose memory of the
//            2-D DCT. Rows are written into memory by row index. Columns are
//            then read back by column index and presented one at a time from
//            a registered valid/ready output stage. Single buffered.
// Revision : 1.0  initial release
// ============================================================================
module transram_ctrl #(
  parameter int DW = 12,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          row_valid_i,
  output logic          row_ready_o,
  output logic          ram_rw_o,
  output logic [2:0]    ram_addr_o,
  input  logic [DW-1:0] ram_out0_i,
  input  logic [DW-1:0] ram_out1_i,
  input  logic [DW-1:0] ram_out2_i,
  input  logic [DW-1:0] ram_out3_i,
  input  logic [DW-1:0] ram_out4_i,
  input  logic [DW-1:0] ram_out5_i,
  input  logic [DW-1:0] ram_out6_i,
  input  logic [DW-1:0] ram_out7_i,
  output logic          col_valid_o,
  input  logic          col_ready_i,
  output logic [DW-1:0] col_data0_o,
  output logic [DW-1:0] col_data1_o,
  output logic [DW-1:0] col_data2_o,
  output logic [DW-1:0] col_data3_o,
  output logic [DW-1:0] col_data4_o,
  output logic [DW-1:0] col_data5_o,
  output logic [DW-1:0] col_data6_o,
  output logic [DW-1:0] col_data7_o,
  output logic [2:0]    col_idx_o,
  output logic          blk_done_o,
  output logic [CW-1:0] blk_cnt_o
);

  typedef enum logic [0:0] {
    ST_WR = 1'b0,
    ST_RD = 1'b1
  } state_t;

  localparam logic [CW-1:0] C_BLK_ONE = CW'(1);

  state_t        state_q;
  logic [2:0]    row_cnt_q;
  logic [2:0]    col_cnt_q;
  logic          col_valid_q;
  logic [DW-1:0] col_data_q [8];
  logic [2:0]    col_idx_q;
  logic          blk_done_q;
  logic [CW-1:0] blk_cnt_q;

  logic [DW-1:0] w_ram_col [8];
  logic          w_accept;
  logic          w_load;
  logic          w_consume;

  assign w_ram_col[0] = ram_out0_i;
  assign w_ram_col[1] = ram_out1_i;
  assign w_ram_col[2] = ram_out2_i;
  assign w_ram_col[3] = ram_out3_i;
  assign w_ram_col[4] = ram_out4_i;
  assign w_ram_col[5] = ram_out5_i;
  assign w_ram_col[6] = ram_out6_i;
  assign w_ram_col[7] = ram_out7_i;

  // A row is taken only in WR; row_valid is ignored in RD so ram_rw can never
  // assert while columns are being read.
  assign w_accept  = (state_q == ST_WR) && row_valid_i;
  assign w_consume = col_valid_q && col_ready_i;
  // The output register may be refilled when empty or when its current
  // column leaves in the same cycle.
  assign w_load    = (state_q == ST_RD) && (!col_valid_q || col_ready_i);

  // Memory-side controls depend only on state, counters and row_valid, so
  // col_ready has no path to row_ready.
  assign row_ready_o = (state_q == ST_WR);
  assign ram_rw_o    = w_accept;
  assign ram_addr_o  = (state_q == ST_WR) ? row_cnt_q : col_cnt_q;

  assign col_valid_o = col_valid_q;
  assign col_data0_o = col_data_q[0];
  assign col_data1_o = col_data_q[1];
  assign col_data2_o = col_data_q[2];
  assign col_data3_o = col_data_q[3];
  assign col_data4_o = col_data_q[4];
  assign col_data5_o = col_data_q[5];
  assign col_data6_o = col_data_q[6];
  assign col_data7_o = col_data_q[7];
  assign col_idx_o   = col_idx_q;
  assign blk_done_o  = blk_done_q;
  assign blk_cnt_o   = blk_cnt_q;

  // Write/read sequencer with the registered column output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_WR;
      row_cnt_q   <= 3'd0;
      col_cnt_q   <= 3'd0;
      col_valid_q <= 1'b0;
      col_idx_q   <= 3'd0;
      blk_done_q  <= 1'b0;
      blk_cnt_q   <= '0;
      for (int k = 0; k < 8; k++) begin
        col_data_q[k] <= '0;
      end
    end else begin
      blk_done_q <= 1'b0;
      if (w_consume && (col_idx_q == 3'd7)) begin
        blk_done_q <= 1'b1;
        blk_cnt_q  <= blk_cnt_q + C_BLK_ONE;
      end
      // A load below overrides this clear when both happen together.
      if (w_consume) begin
        col_valid_q <= 1'b0;
      end
      case (state_q)
        ST_WR: begin
          if (w_accept) begin
            row_cnt_q <= row_cnt_q + 3'd1;
            if (row_cnt_q == 3'd7) begin
              state_q <= ST_RD;
            end
          end
        end
        ST_RD: begin
          if (w_load) begin
            for (int k = 0; k < 8; k++) begin
              col_data_q[k] <= w_ram_col[k];
            end
            col_idx_q   <= col_cnt_q;
            col_valid_q <= 1'b1;
            col_cnt_q   <= col_cnt_q + 3'd1;
            if (col_cnt_q == 3'd7) begin
              state_q <= ST_WR;
            end
          end
        end
        default: state_q <= ST_WR;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_transram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_transram_ctrl
// Purpose  : Self-checking bench for transram_ctrl with a transpose-memory
//            model, a block-level reference model and directed stimulus.
// Revision : 1.0  initial release
// ============================================================================
module tb_transram_ctrl;
  localparam int DW = 12;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          row_valid = 1'b0;
  logic          row_ready;
  logic          ram_rw;
  logic [2:0]    ram_addr;
  logic [DW-1:0] in_row [8];
  logic [DW-1:0] mem [8][8];
  logic [DW-1:0] ram_out [8];
  logic          col_valid;
  logic          col_ready = 1'b0;
  logic [DW-1:0] col_data [8];
  logic [2:0]    col_idx;
  logic          blk_done;
  logic [CW-1:0] blk_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int rdy_mode = 0;

  always #5 clk = ~clk;

  transram_ctrl #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .row_valid_i(row_valid), .row_ready_o(row_ready),
    .ram_rw_o(ram_rw), .ram_addr_o(ram_addr),
    .ram_out0_i(ram_out[0]), .ram_out1_i(ram_out[1]),
    .ram_out2_i(ram_out[2]), .ram_out3_i(ram_out[3]),
    .ram_out4_i(ram_out[4]), .ram_out5_i(ram_out[5]),
    .ram_out6_i(ram_out[6]), .ram_out7_i(ram_out[7]),
    .col_valid_o(col_valid), .col_ready_i(col_ready),
    .col_data0_o(col_data[0]), .col_data1_o(col_data[1]),
    .col_data2_o(col_data[2]), .col_data3_o(col_data[3]),
    .col_data4_o(col_data[4]), .col_data5_o(col_data[5]),
    .col_data6_o(col_data[6]), .col_data7_o(col_data[7]),
    .col_idx_o(col_idx), .blk_done_o(blk_done), .blk_cnt_o(blk_cnt)
  );

  // Transpose memory: row write by address, column read by address.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) mem[r][c] <= '0;
    end else if (ram_rw) begin
      for (int c = 0; c < 8; c++) mem[ram_addr][c] <= in_row[c];
    end
  end

  always_comb begin
    for (int k = 0; k < 8; k++) ram_out[k] = mem[k][ram_addr];
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0][DW-1:0] exp_cols [$];
  int                 exp_idx  [$];
  logic [DW-1:0]      m_blk [8][8];
  int                 m_rows = 0;
  int                 m_loads = 0;
  logic [CW-1:0]      m_cnt = '0;
  bit                 p_valid = 0, p_ready = 0, p_done_due = 0;
  logic [7:0][DW-1:0] p_data, cur, colv;
  logic [2:0]         p_idx;
  bit                 load_obs;

  always @(negedge clk) begin
    for (int k = 0; k < 8; k++) cur[k] = col_data[k];
    if (rst) begin
      exp_cols.delete(); exp_idx.delete();
      m_rows = 0; m_loads = 0; m_cnt = '0;
      p_valid = 0; p_ready = 0; p_done_due = 0;
      chk("rst_row_ready", row_ready, 1);
      chk("rst_ram_rw", ram_rw, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_col_valid", col_valid, 0);
      chk("rst_col_data", cur, 0);
      chk("rst_col_idx", col_idx, 0);
      chk("rst_blk_done", blk_done, 0);
      chk("rst_blk_cnt", blk_cnt, 0);
    end else begin
      if (p_valid && !p_ready) begin
        chk("hold_valid", col_valid, 1);
        chk("hold_data", cur, p_data);
        chk("hold_idx", col_idx, p_idx);
      end
      load_obs = col_valid && (!p_valid || p_ready);
      if (load_obs) begin
        if (exp_cols.size() == 0) chk("spurious_load", col_valid, 0);
        else begin
          chk("col_data", cur, exp_cols.pop_front());
          chk("col_idx", col_idx, exp_idx.pop_front());
          m_loads--;
        end
      end
      if (p_done_due) m_cnt = m_cnt + 1'b1;
      chk("blk_done", blk_done, p_done_due);
      chk("blk_cnt", blk_cnt, m_cnt);
      chk("row_ready", row_ready, m_loads == 0);
      chk("ram_rw", ram_rw, (m_loads == 0) && row_valid);
      chk("ram_addr", ram_addr, (m_loads == 0) ? m_rows : 8 - m_loads);
      // Events that happen at the coming rising edge.
      if (row_valid && m_loads == 0) begin
        for (int c = 0; c < 8; c++) m_blk[m_rows][c] = in_row[c];
        m_rows++;
        if (m_rows == 8) begin
          for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < 8; k++) colv[k] = m_blk[k][c];
            exp_cols.push_back(colv);
            exp_idx.push_back(c);
          end
          m_rows = 0;
          m_loads = 8;
        end
      end
      p_done_due = col_valid && col_ready && (col_idx == 3'd7);
      p_valid = col_valid; p_ready = col_ready; p_data = cur; p_idx = col_idx;
    end
  end

  // ---------------- downstream ready driver ----------------
  initial begin
    int ph = 0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: col_ready = 1'b1;
        1: col_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
        default: col_ready = 1'($urandom_range(0, 1));
      endcase
      ph++;
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [DW-1:0] val(input int kind, input int b, input int r, input int c);
    case (kind)
      0: return DW'(16 * r + c);
      1: return DW'(12'hABC + 8 * r + c);
      default: return DW'(64 * b + 8 * r + c);
    endcase
  endfunction

  task automatic put_row(input int kind, input int b, input int r);
    bit acc = 0;
    for (int c = 0; c < 8; c++) in_row[c] = val(kind, b, r, c);
    row_valid = 1'b1;
    for (int n = 0; n < 200 && !acc; n++) begin
      acc = row_ready;
      @(posedge clk); #1;
    end
    if (!acc) chk("row_accept_timeout", acc, 1);
    row_valid = 1'b0;
  endtask

  task automatic send_block(input int kind, input int b, input bit gaps);
    for (int r = 0; r < 8; r++) begin
      if (gaps && $urandom_range(0, 1) == 1)
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      put_row(kind, b, r);
    end
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int n = 0; n < 400 && !done; n++) begin
      @(posedge clk); #1;
      done = (m_loads == 0) && !col_valid;
    end
    if (!done) chk("drain_timeout", done, 1);
  endtask

  initial begin
    for (int c = 0; c < 8; c++) in_row[c] = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("post_rst_row_ready", row_ready, 1);

    // Basic transpose with literal timing/data pins.
    rdy_mode = 0;
    @(posedge clk); #1;
    send_block(0, 0, 0);
    chk("basic_valid_E", col_valid, 0);
    chk("basic_ready_E", row_ready, 0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("basic_valid_run", col_valid, 1);
      chk("basic_idx", col_idx, i);
      chk("basic_d2", col_data[2], 32 + i);
      chk("basic_d7", col_data[7], 112 + i);
    end
    chk("basic_ready_back", row_ready, 1);
    chk("basic_done_early", blk_done, 0);
    @(posedge clk); #1;
    chk("basic_done", blk_done, 1);
    chk("basic_cnt", blk_cnt, 1);
    chk("basic_valid_off", col_valid, 0);
    @(posedge clk); #1;
    chk("basic_done_once", blk_done, 0);

    // Backpressure 1,0,0,1 pattern.
    rdy_mode = 1;
    send_block(0, 0, 0);
    wait_idle();
    chk("bp_cnt", blk_cnt, 2);

    // Row gaps, then row_valid held high through RD.
    rdy_mode = 2;
    send_block(2, 3, 1);
    for (int c = 0; c < 8; c++) in_row[c] = 12'hFFF;
    row_valid = 1'b1;
    for (int n = 0; n < 100 && !row_ready; n++) begin @(posedge clk); #1; end
    row_valid = 1'b0;
    wait_idle();
    chk("gap_cnt", blk_cnt, 3);

    // Mid-block asynchronous reset after 5 rows.
    rdy_mode = 0;
    for (int r = 0; r < 5; r++) put_row(2, 1, r);
    #2 rst = 1'b1;
    #1;
    chk("async_row_ready", row_ready, 1);
    chk("async_ram_addr", ram_addr, 0);
    chk("async_blk_cnt", blk_cnt, 0);
    chk("async_col_valid", col_valid, 0);
    @(posedge clk); #1 rst = 1'b0;
    chk("async_ready_rel", row_ready, 1);
    send_block(1, 0, 0);
    @(posedge clk); #1;
    chk("abc_first_d0", col_data[0], 12'hABC);
    chk("abc_first_d3", col_data[3], 12'hABC + 24);
    wait_idle();
    chk("abc_cnt", blk_cnt, 1);

    // Counter wrap: continuing from 1 -> 2,3,0,1.
    rdy_mode = 2;
    for (int b = 0; b < 4; b++) begin
      send_block(2, b, 1);
      wait_idle();
      chk("wrap_cnt", blk_cnt, (2 + b) % 4);
    end
    chk("queue_empty", exp_cols.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", n_tests);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/transram_ctrl.md
# transram_ctrl

Sequencer and output stage for the 8x8 transpose memory in the 2-D DCT datapath. It accepts 8-sample rows from the row 1-D DCT with a valid/ready handshake, and drives the transpose memory's rw/addr so each row lands in memory row `row_cnt`. After 8 rows it reads the 8 columns back and presents each one, registered, to the column 1-D DCT with a valid/ready handshake. The buffer is single: a new block is not accepted until all 8 columns of the current block have been captured.

## Interface
- DW, 12, sample width; must equal the memory word width.
- CW, 16, width of the block counter.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- row_valid  in  1  upstream row present on the memory inputs in0..in7.
- row_ready  out  1  row accepted this cycle when row_valid & row_ready.
- ram_rw  out  1  memory write enable; 1 = write, 0 = read.
- ram_addr  out  3  row index while writing, column index while reading.
- ram_out0..ram_out7  in  DW each  combinational column read data from memory.
- col_valid  out  1  col_data holds a valid column.
- col_ready  in  1  downstream consumes the column when col_valid & col_ready.
- col_data0..col_data7  out  DW each  registered column; col_dataK = element of row K.
- col_idx  out  3  column number of the column in col_data.
- blk_done  out  1  one-cycle pulse when column 7 of a block is consumed downstream.
- blk_cnt  out  CW  count of completed blocks; wraps modulo 2^CW.

## Operation
- State machine: WR and RD only; reset state is WR.
- WR state:
  - row_ready = 1; ram_rw = row_valid; ram_addr = row_cnt.
  - On each accept, row_cnt increments.
  - An accept with row_cnt = 7 sets row_cnt to 0 and moves to RD.
- RD state:
  - row_ready = 0; ram_rw = 0; ram_addr = col_cnt.
  - Output register is loadable when col_valid = 0, or when col_valid & col_ready (same-cycle replace).
  - When loadable: col_dataK <= ram_outK, col_idx <= col_cnt, col_valid <= 1, col_cnt increments.
  - The load with col_cnt = 7 sets col_cnt to 0 and moves to WR.
- col_valid clears on consume when no load happens in the same cycle.
- Once col_valid = 1, col_data and col_idx are held stable until consumed (no change while col_ready = 0).
- Column 7 may still be waiting in the output register after the return to WR. The next block's rows are accepted meanwhile; the captured data is unaffected.
- blk_done pulses and blk_cnt increments on consume of a column with col_idx = 7.
- row_valid is ignored in RD; ram_rw must never be 1 in RD.
- Reset mid-block: the partial block is discarded, counters clear, state returns to WR, and the transpose memory is cleared by the same rst.

## Timing
- Reset values: row_ready = 1, ram_rw = 0, ram_addr = 0, col_valid = 0, col_data = 0, col_idx = 0, blk_done = 0, blk_cnt = 0.
- row_ready, ram_rw and ram_addr are combinational from state, counters and row_valid. No combinational path runs from col_ready to row_ready.
- Row 7 is accepted at edge E. col_valid rises at edge E+1 with column 0; the memory write at E is visible to the read in cycle E+1.
- With col_ready held at 1, columns 0..7 are output on consecutive cycles. The first row of the next block can be accepted in the cycle after column 7 is loaded.
- Minimum block period: 8 write cycles + 8 read cycles = 16 cycles.
- Backpressure: each cycle with col_ready = 0 while col_valid = 1 adds one cycle.

## Test plan
- Reset: assert rst mid-cycle -> all outputs at reset values immediately; row_ready = 1 after release.
- Basic transpose: 8 back-to-back rows with in_c = 16*r + c, col_ready = 1 -> col_valid high 8 consecutive cycles starting one cycle after row 7 is accepted; column c gives col_dataK = 16*K + c, col_idx = c; blk_done pulses once; blk_cnt = 1.
- Backpressure: same stimulus with col_ready toggled 1,0,0,1,... -> no column lost or duplicated; col_data stable while stalled; row_ready = 0 until column 7 is loaded.
- Row gaps and illegal writes: row_valid deasserted randomly in WR, and held high throughout RD -> ram_rw = 0 in every RD cycle; output data still matches the transpose.
- Mid-block reset: reset after 5 rows, then a full new block with values 0xABC+K -> only the new block appears; blk_cnt = 1.
- Counter wrap (CW = 2): 5 blocks -> blk_cnt sequence 1,2,3,0,1.
